// File: rtl/llc_req_arbiter_if.sv
// llc_req_arbiter_if: request, issue and completion signals between the trace decoder, the arbiter and the LLC
interface llc_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int OP_WIDTH   = 4
);
    logic                  snp_valid;
    logic [OP_WIDTH-1:0]   snp_op;
    logic [ADDR_WIDTH-1:0] snp_addr;
    logic                  snp_ready;
    logic                  l1d_valid;
    logic [OP_WIDTH-1:0]   l1d_op;
    logic [ADDR_WIDTH-1:0] l1d_addr;
    logic                  l1d_ready;
    logic                  l1i_valid;
    logic [ADDR_WIDTH-1:0] l1i_addr;
    logic                  l1i_ready;
    logic                  llc_valid;
    logic [OP_WIDTH-1:0]   llc_op;
    logic [ADDR_WIDTH-1:0] llc_addr;
    logic [1:0]            llc_src;
    logic                  llc_done;
    logic                  busy;

    modport master (
        output snp_valid, snp_op, snp_addr, l1d_valid, l1d_op, l1d_addr, l1i_valid, l1i_addr, llc_done,
        input  snp_ready, l1d_ready, l1i_ready, llc_valid, llc_op, llc_addr, llc_src, busy
    );

    modport slave (
        input  snp_valid, snp_op, snp_addr, l1d_valid, l1d_op, l1d_addr, l1i_valid, l1i_addr, llc_done,
        output snp_ready, l1d_ready, l1i_ready, llc_valid, llc_op, llc_addr, llc_src, busy
    );
endinterface

// File: rtl/llc_req_arbiter.sv
// llc_req_arbiter: issues one snoop/L1D/L1I op at a time into the LLC pipeline and holds it until llc_done
module llc_req_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int OP_WIDTH     = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    llc_req_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
    localparam logic [OP_WIDTH-1:0] OP_IFETCH = OP_WIDTH'(2);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state, state_d;
    logic [OP_WIDTH-1:0]   op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            src_q;
    logic                  rr_ptr;
    logic [CW-1:0]         starve_cnt;
    logic                  idle, l1_any, l1_first, snp_gnt, l1d_gnt, l1i_gnt;

    // Readys are suppressed during reset so nothing is granted while the block is held.
    always_comb begin
        idle     = state == IDLE && !reset;
        l1_any   = bus.l1d_valid | bus.l1i_valid;
        l1_first = starve_cnt == STARVE_MAX && l1_any;
        snp_gnt  = idle && bus.snp_valid && !l1_first;
        l1d_gnt  = idle && !snp_gnt && bus.l1d_valid && (!rr_ptr || !bus.l1i_valid);
        l1i_gnt  = idle && !snp_gnt && bus.l1i_valid && (rr_ptr || !bus.l1d_valid);
        state_d  = state == IDLE ? ((snp_gnt | l1d_gnt | l1i_gnt) ? BUSY : IDLE)
                                 : (bus.llc_done ? IDLE : BUSY);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // rr_ptr: 0 favours L1D, 1 favours L1I.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= 2'd0;
            rr_ptr     <= 1'b0;
            starve_cnt <= '0;
        end else if (snp_gnt) begin
            op_q   <= bus.snp_op;
            addr_q <= bus.snp_addr;
            src_q  <= 2'd1;
            if (l1_any && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
        end else if (l1d_gnt) begin
            op_q       <= bus.l1d_op;
            addr_q     <= bus.l1d_addr;
            src_q      <= 2'd2;
            rr_ptr     <= 1'b1;
            starve_cnt <= '0;
        end else if (l1i_gnt) begin
            op_q       <= OP_IFETCH;
            addr_q     <= bus.l1i_addr;
            src_q      <= 2'd3;
            rr_ptr     <= 1'b0;
            starve_cnt <= '0;
        end else if (state == BUSY && bus.llc_done) begin
            src_q <= 2'd0;
        end
    end

    assign bus.snp_ready = snp_gnt;
    assign bus.l1d_ready = l1d_gnt;
    assign bus.l1i_ready = l1i_gnt;
    assign bus.llc_valid = state == BUSY;
    assign bus.busy      = state == BUSY;
    assign bus.llc_op    = op_q;
    assign bus.llc_addr  = addr_q;
    assign bus.llc_src   = src_q;
endmodule
